// File: rtl/display_panel_capture.sv
// ---------------------------------------------------------------------------
// display_panel_capture
//
// Sink model for a HUB75-style panel stream. It runs in the driver's clock
// domain, so oclk, lat and oe are sampled as ordinary inputs and never used
// as clocks.
//   - sdata is shifted in on every oclk rise. After exactly COLUMNS rises,
//     the first bit sent sits at column 0.
//   - A lat rise copies the shift chain into the latch register and records
//     the row address.
//   - While in IDLE, lit time is accumulated per column.
//   - A change of the row address flushes the accumulated row as one word per
//     column over a valid/ready stream.
//
// Optional feature (macro DISPLAY_CAPTURE_CYCLE_WEIGHT_EN):
//   defined   - every clk cycle with oe=1 adds 1 per lit column
//   undefined - every oe fall (the end of one display window) adds 1 per lit
//               column
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   row                       row address from the driver
//   sdata, oclk, lat, oe      serial panel stream
//   out_valid / out_ready     result stream handshake
//   out_row, out_column       identify the result word
//   out_value                 accumulated on-time of that column
//   out_last                  final column of the row
//   frame_done                one-cycle pulse when the row wraps from ROWS-1 to 0
//   overrun                   sticky: an oe fall occurred while flushing
//   saturated                 sticky: an accumulator was clamped
//
// Handshake: a word transfers on a clock edge where out_valid and out_ready
// are both high. While out_valid is high and out_ready is low, every out_*
// field holds steady. out_valid falls only after the last column of the row
// has been accepted.
// The FSM state is visible directly on out_valid (high exactly in FLUSH).
// ---------------------------------------------------------------------------
module display_panel_capture #(
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int ACCWIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ROWS)-1:0]    row,
    input  logic                       sdata,
    input  logic                       oclk,
    input  logic                       lat,
    input  logic                       oe,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(ROWS)-1:0]    out_row,
    output logic [$clog2(COLUMNS)-1:0] out_column,
    output logic [ACCWIDTH-1:0]        out_value,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       overrun,
    output logic                       saturated
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLUMNS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [ACCWIDTH-1:0] ACC_MAX  = '1;
    localparam logic [RW-1:0]       LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0]       LAST_COL = CW'(COLUMNS - 1);

    logic [COLUMNS-1:0]  shreg_q, shreg_d;
    logic [COLUMNS-1:0]  latreg_q, latreg_d;
    logic [ACCWIDTH-1:0] acc_q [COLUMNS];
    logic [ACCWIDTH-1:0] acc_d [COLUMNS];
    logic                oclk_q, lat_q, oe_q;
    logic [RW-1:0]       row_q, cur_row_q, cur_row_d, flush_row_q, flush_row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [0:0]          state_q, state_d;
    logic                overrun_q, overrun_d, saturated_q, saturated_d;

    logic oclk_rise, lat_rise, oe_fall, acc_event;

    assign oclk_rise = oclk & ~oclk_q;
    assign lat_rise  = lat & ~lat_q;
    assign oe_fall   = ~oe & oe_q;

`ifdef DISPLAY_CAPTURE_CYCLE_WEIGHT_EN
    assign acc_event = oe;       // count each lit clock cycle
`else
    assign acc_event = oe_fall;  // count each completed display window
`endif

    always_comb begin
        shreg_d     = shreg_q;
        latreg_d    = latreg_q;
        cur_row_d   = cur_row_q;
        flush_row_d = flush_row_q;
        col_d       = col_q;
        state_d     = state_q;
        overrun_d   = overrun_q;
        saturated_d = saturated_q;
        for (int c = 0; c < COLUMNS; c++) begin
            acc_d[c] = acc_q[c];
        end

        if (oclk_rise) begin
            shreg_d = {sdata, shreg_q[COLUMNS-1:1]};
        end
        // A coincident shift and latch hand the latch the post-shift chain.
        if (lat_rise) begin
            latreg_d  = shreg_d;
            cur_row_d = row;
        end

        case (state_q)
            ST_IDLE: begin
                for (int c = 0; c < COLUMNS; c++) begin
                    if (acc_event && latreg_q[c]) begin
                        if (acc_q[c] == ACC_MAX) begin
                            saturated_d = 1'b1;
                        end else begin
                            acc_d[c] = acc_q[c] + 1'b1;
                        end
                    end
                end
                if (row != row_q) begin
                    state_d     = ST_FLUSH;
                    flush_row_d = cur_row_q;
                    col_d       = '0;
                end
            end
            default: begin
                // Lit time ending while flushing is dropped but flagged.
                if (oe_fall) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    acc_d[col_q] = '0;
                    if (col_q == LAST_COL) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            latreg_q    <= '0;
            oclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_q        <= 1'b0;
            row_q       <= '0;
            cur_row_q   <= '0;
            flush_row_q <= '0;
            col_q       <= '0;
            state_q     <= ST_IDLE;
            overrun_q   <= 1'b0;
            saturated_q <= 1'b0;
            for (int c = 0; c < COLUMNS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            shreg_q     <= shreg_d;
            latreg_q    <= latreg_d;
            oclk_q      <= oclk;
            lat_q       <= lat;
            oe_q        <= oe;
            row_q       <= row;
            cur_row_q   <= cur_row_d;
            flush_row_q <= flush_row_d;
            col_q       <= col_d;
            state_q     <= state_d;
            overrun_q   <= overrun_d;
            saturated_q <= saturated_d;
            for (int c = 0; c < COLUMNS; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign out_valid  = (state_q == ST_FLUSH);
    assign out_row    = flush_row_q;
    assign out_column = col_q;
    assign out_value  = acc_q[col_q];
    assign out_last   = out_valid && (col_q == LAST_COL);
    assign frame_done = (row_q == LAST_ROW) && (row == '0);
    assign overrun    = overrun_q;
    assign saturated  = saturated_q;

endmodule

// File: tb/tb_display_panel_capture.sv
// Bench for display_panel_capture. Two instances share one stimulus stream.
// The first uses 16-bit accumulators. The second uses 4-bit accumulators, so
// that saturation can be reached in a few windows. The model keeps an
// unbounded lit-count per column; the value each instance should report is
// that count clamped to its own accumulator width.
module tb_display_panel_capture;
    localparam int ROWS    = 8;
    localparam int COLUMNS = 32;
    localparam int ACCW    = 16;
    localparam int SATW    = 4;
`ifdef DISPLAY_CAPTURE_CYCLE_WEIGHT_EN
    localparam bit CYCLE_MODE = 1'b1;
`else
    localparam bit CYCLE_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, sdata, oclk, lat, oe, out_ready;
    logic [2:0] row;

    logic        ov, olast, fdone, ovr, sat;
    logic [2:0]  orow;
    logic [4:0]  ocol;
    logic [15:0] oval;
    logic        s_ov, s_olast, s_fdone, s_ovr, s_sat;
    logic [2:0]  s_orow;
    logic [4:0]  s_ocol;
    logic [3:0]  s_oval;

    display_panel_capture #(.ROWS(ROWS), .COLUMNS(COLUMNS), .ACCWIDTH(ACCW)) dut (
        .clk(clk), .rst(rst), .row(row), .sdata(sdata), .oclk(oclk), .lat(lat), .oe(oe),
        .out_valid(ov), .out_ready(out_ready), .out_row(orow), .out_column(ocol),
        .out_value(oval), .out_last(olast), .frame_done(fdone), .overrun(ovr), .saturated(sat)
    );

    display_panel_capture #(.ROWS(ROWS), .COLUMNS(COLUMNS), .ACCWIDTH(SATW)) dut_sat (
        .clk(clk), .rst(rst), .row(row), .sdata(sdata), .oclk(oclk), .lat(lat), .oe(oe),
        .out_valid(s_ov), .out_ready(out_ready), .out_row(s_orow), .out_column(s_ocol),
        .out_value(s_oval), .out_last(s_olast), .frame_done(s_fdone), .overrun(s_ovr),
        .saturated(s_sat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: lit count per column, last 32 bits sent, latched row.
    int                 cnt [COLUMNS];
    logic [COLUMNS-1:0] shreg_m, lat_m;
    logic [2:0]         cur_row_m;
    bit                 sat_m;

    function automatic int clampv(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [63:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sdata = b[i];
            oclk  = 1'b1;
            step();
            oclk  = 1'b0;
            step();
        end
        // Only the last COLUMNS bits survive; the oldest of those ends up in column 0.
        for (int c = 0; c < COLUMNS; c++) shreg_m[c] = b[n - COLUMNS + c];
    endtask

    task automatic do_latch();
        lat = 1'b1;
        step();
        lat = 1'b0;
        step();
        lat_m     = shreg_m;
        cur_row_m = row;
    endtask

    task automatic window(input int n);
        oe = 1'b1;
        repeat (n) step();
        oe = 1'b0;
        step();
        for (int c = 0; c < COLUMNS; c++) begin
            if (lat_m[c]) begin
                cnt[c] += CYCLE_MODE ? n : 1;
                if (cnt[c] > (1 << SATW) - 1) sat_m = 1'b1;
            end
        end
    endtask

    task automatic change_row(input logic [2:0] r);
        row = r;
        step();
    endtask

    // mode 0: ready always high, 1: random ready, 2: repeating 1,0,0,1
    task automatic flush(input int n_words, input int mode);
        int   acc_n;
        int   cyc;
        logic rdy;
        acc_n = 0;
        cyc   = 0;
        while (acc_n < n_words && cyc < 600) begin
            checks++;
            if (ov !== 1'b1) begin
                errors++;
                $display("FAIL flush_valid word=%0d: got %0b expected 1", acc_n, ov);
                break;
            end
            checks++;
            if (ocol !== 5'(acc_n)) begin
                errors++;
                $display("FAIL flush_column: got %0d expected %0d", ocol, acc_n);
            end
            checks++;
            if (orow !== cur_row_m) begin
                errors++;
                $display("FAIL flush_row: got %0d expected %0d", orow, cur_row_m);
            end
            checks++;
            if (oval !== 16'(clampv(cnt[acc_n], ACCW))) begin
                errors++;
                $display("FAIL flush_value col=%0d: got %0d expected %0d", acc_n, oval,
                         clampv(cnt[acc_n], ACCW));
            end
            checks++;
            if (s_oval !== 4'(clampv(cnt[acc_n], SATW))) begin
                errors++;
                $display("FAIL flush_sat_value col=%0d: got %0d expected %0d", acc_n, s_oval,
                         clampv(cnt[acc_n], SATW));
            end
            checks++;
            if (olast !== (acc_n == COLUMNS - 1)) begin
                errors++;
                $display("FAIL flush_last col=%0d: got %0b expected %0b", acc_n, olast,
                         (acc_n == COLUMNS - 1));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            out_ready = rdy;
            step();
            cyc++;
            if (rdy) begin
                cnt[acc_n] = 0;
                acc_n++;
            end
        end
        out_ready = 1'b0;
        if (cyc >= 600) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout: got %0d words expected %0d", acc_n, n_words);
        end
        if (n_words == COLUMNS) begin
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL flush_end_valid: got %0b expected 0", ov);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ov !== 1'b0 || s_ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b/%0b expected 0", ov, s_ov);
        end
        checks++;
        if (olast !== 1'b0 || fdone !== 1'b0 || oval !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got last=%0b frame=%0b value=%0d expected 0",
                     olast, fdone, oval);
        end
        checks++;
        if (ovr !== 1'b0 || sat !== 1'b0 || s_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got ovr=%0b sat=%0b/%0b expected 0", ovr, sat, s_sat);
        end
    endtask

    task automatic test_single_window();
        shift_bits(64'hA5A5_0001, 32);
        do_latch();
        window(4);
        change_row(3'd1);
        flush(COLUMNS, 0);
    endtask

    task automatic test_multi_window();
        do_latch();
        for (int w = 0; w < 3; w++) window(CYCLE_MODE ? 64 : $urandom_range(1, 6));
        change_row(3'd2);
        flush(COLUMNS, 1);
    endtask

    task automatic test_ready_toggle();
        logic [63:0] b;
        int n;
        b = {$urandom, $urandom};
        n = $urandom_range(32, 40);
        shift_bits(b, n);
        do_latch();
        window($urandom_range(1, 5));
        window($urandom_range(1, 5));
        change_row(3'd3);
        flush(COLUMNS, 2);
        // No new lit time: the next flush must read back cleared accumulators.
        change_row(3'd4);
        flush(COLUMNS, 0);
    endtask

    task automatic test_saturation();
        shift_bits(64'hFFFF_FFFF, 32);
        do_latch();
        for (int w = 0; w < 20; w++) window(1);
        checks++;
        if (s_sat !== sat_m || sat !== 1'b0) begin
            errors++;
            $display("FAIL saturation_flag: got %0b/%0b expected %0b/0", s_sat, sat, sat_m);
        end
        change_row(3'd5);
        flush(COLUMNS, 1);
        checks++;
        if (s_sat !== 1'b1) begin
            errors++;
            $display("FAIL saturation_sticky: got %0b expected 1", s_sat);
        end
    endtask

    task automatic test_overrun();
        do_latch();
        window(2);
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_idle: got %0b expected 0", ovr);
        end
        change_row(3'd6);
        oe = 1'b1;
        repeat (3) step();
        oe = 1'b0;
        step();
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %0b expected 1", ovr);
        end
        flush(COLUMNS, 1);
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %0b expected 1", ovr);
        end
    endtask

    task automatic test_frame_sweep();
        logic [2:0] seq [3];
        logic [2:0] prev;
        int pulses;
        seq    = '{3'd7, 3'd0, 3'd1};
        prev   = row;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            row = seq[i];
            #1;
            checks++;
            if (fdone !== (prev == 3'd7 && seq[i] == 3'd0)) begin
                errors++;
                $display("FAIL frame_done row %0d->%0d: got %0b expected %0b", prev, seq[i],
                         fdone, (prev == 3'd7 && seq[i] == 3'd0));
            end
            if (fdone === 1'b1) pulses++;
            step();
            flush(COLUMNS, 0);
            prev = seq[i];
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_mid_flush();
        shift_bits({32'd0, $urandom}, 32);
        do_latch();
        window(3);
        change_row(3'd2);
        flush(10, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (ov !== 1'b0 || oval !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_flush: got valid=%0b value=%0d expected 0/0", ov, oval);
        end
        checks++;
        if (ovr !== 1'b0 || s_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky_clear: got ovr=%0b sat=%0b expected 0", ovr, s_sat);
        end
        for (int c = 0; c < COLUMNS; c++) cnt[c] = 0;
        sat_m     = 1'b0;
        lat_m     = '0;
        cur_row_m = 3'd0;
        row       = 3'd0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got %0b expected 0", ov);
        end
        change_row(3'd3);
        flush(COLUMNS, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        row = '0; sdata = 1'b0; oclk = 1'b0; lat = 1'b0; oe = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < COLUMNS; c++) cnt[c] = 0;
        shreg_m = '0; lat_m = '0; cur_row_m = '0; sat_m = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        test_reset();
        test_single_window();
        test_multi_window();
        test_ready_toggle();
        test_saturation();
        test_overrun();
        test_frame_sweep();
        test_reset_mid_flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
